// File: rtl/dm_cache_pkg.sv
// Shared definitions for the direct-mapped cache controller.
// Holds the geometry constants, the sequencer state encoding and the
// address field-extraction helpers used by the controller and tag store.
package dm_cache_pkg;

   localparam int unsigned ADDR_W  = 32'd32;
   localparam int unsigned TAG_W   = 32'd20;
   localparam int unsigned INDEX_W = 32'd8;
   localparam int unsigned WOFF_W  = 32'd2;
   localparam int unsigned DATA_W  = 32'd32;
   localparam int unsigned LINES   = 32'd256;

   // Address layout: [31:12] tag, [11:4] index, [3:2] word offset, [1:0] byte
   localparam int unsigned WOFF_LSB  = 32'd2;
   localparam int unsigned INDEX_LSB = WOFF_LSB + WOFF_W;
   localparam int unsigned TAG_LSB   = INDEX_LSB + INDEX_W;

   localparam logic [WOFF_W-1:0] CNT_LAST = {WOFF_W{1'b1}};

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOOKUP  = 3'd1,
      ST_WB_RD   = 3'd2,
      ST_WB_WR   = 3'd3,
      ST_RF_REQ  = 3'd4,
      ST_RF_WAIT = 3'd5
   } state_t;

   function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
      return TAG_W'(addr >> TAG_LSB);
   endfunction

   function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
      return INDEX_W'(addr >> INDEX_LSB);
   endfunction

   function automatic logic [WOFF_W-1:0] get_woff(input logic [ADDR_W-1:0] addr);
      return WOFF_W'(addr >> WOFF_LSB);
   endfunction

endpackage

// File: rtl/dm_cache_tag_store.sv
// Tag, valid and dirty state for the direct-mapped cache.
// Ports:
//   clk, rst_n     clock and asynchronous active-low reset (clears valid/dirty)
//   idx, tag       line being looked up / written
//   hit            line valid and its tag equals tag
//   dirty_victim   line valid and dirty (must be written back before refill)
//   victim_tag     tag currently held by the line
//   fill           install tag at idx, valid = 1, dirty = 0
//   set_dirty      mark line idx dirty
module dm_cache_tag_store
   import dm_cache_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [INDEX_W-1:0] idx,
   input  logic [TAG_W-1:0]   tag,
   output logic               hit,
   output logic               dirty_victim,
   output logic [TAG_W-1:0]   victim_tag,
   input  logic               fill,
   input  logic               set_dirty
);

   logic [TAG_W-1:0] tag_mem_r [LINES];
   logic [LINES-1:0] valid_r;
   logic [LINES-1:0] dirty_r;

   // Tag storage: no reset, contents only matter once the valid bit is set
   always_ff @(posedge clk) begin
      if (fill) begin
         tag_mem_r[idx] <= tag;
      end
   end

   // Valid/dirty bits: cleared by reset, fill takes priority over set_dirty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= {LINES{1'b0}};
         dirty_r <= {LINES{1'b0}};
      end else if (fill) begin
         valid_r[idx] <= 1'b1;
         dirty_r[idx] <= 1'b0;
      end else if (set_dirty) begin
         dirty_r[idx] <= 1'b1;
      end
   end

   assign victim_tag   = tag_mem_r[idx];
   assign hit          = valid_r[idx] && (victim_tag == tag);
   assign dirty_victim = valid_r[idx] && dirty_r[idx];

endmodule

// File: rtl/dm_cache_fsm.sv
// Miss-handling sequencer for the direct-mapped cache.
// Accepts one CPU request at a time, looks it up in the tag store, drives the
// cache data array, and runs write-back and refill bursts to main memory.
// Ports:
//   cpu_req_*   request from CPU (valid/ready), cpu_resp_* one-cycle completion
//   arr_*       cache data array word port, read data one cycle after arr_addr
//   mem_*       main memory request (valid/ready) and read-return (rvalid)
module dm_cache_fsm
   import dm_cache_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cpu_req_valid,
   input  logic                      cpu_req_write,
   input  logic [ADDR_W-1:0]         cpu_req_addr,
   input  logic [DATA_W-1:0]         cpu_req_wdata,
   output logic                      cpu_req_ready,
   output logic                      cpu_resp_valid,
   output logic [DATA_W-1:0]         cpu_resp_rdata,
   output logic                      cpu_resp_hit,
   output logic [INDEX_W+WOFF_W-1:0] arr_addr,
   output logic                      arr_we,
   output logic [DATA_W-1:0]         arr_wdata,
   input  logic [DATA_W-1:0]         arr_rdata,
   output logic                      mem_req_valid,
   output logic                      mem_req_write,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic                      mem_ready,
   input  logic                      mem_rvalid,
   input  logic [DATA_W-1:0]         mem_rdata
);

   state_t             state_r, next_s;
   logic               req_write_r;
   logic [TAG_W-1:0]   req_tag_r;
   logic [INDEX_W-1:0] req_idx_r;
   logic [WOFF_W-1:0]  req_woff_r;
   logic [DATA_W-1:0]  req_wdata_r;
   logic [WOFF_W-1:0]  cnt_r;
   logic [DATA_W-1:0]  wb_data_r;
   logic               wb_hold_r;
   logic [DATA_W-1:0]  fill_word_r;
   logic               replay_r;

   logic               accept_s, cnt_clr_s, cnt_inc_s, fill_s, set_dirty_s;
   logic               hit_s, dirty_victim_s;
   logic [TAG_W-1:0]   victim_tag_s;
   logic [1:0]         unused_addr_s;

   // Byte-select bits are not used by a word-organised cache
   assign unused_addr_s = cpu_req_addr[1:0];

   dm_cache_tag_store u_tags (
      .clk          (clk),
      .rst_n        (rst_n),
      .idx          (req_idx_r),
      .tag          (req_tag_r),
      .hit          (hit_s),
      .dirty_victim (dirty_victim_s),
      .victim_tag   (victim_tag_s),
      .fill         (fill_s),
      .set_dirty    (set_dirty_s)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_s;
      end
   end

   // Request latch, burst counter and burst data capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_write_r <= 1'b0;
         req_tag_r   <= {TAG_W{1'b0}};
         req_idx_r   <= {INDEX_W{1'b0}};
         req_woff_r  <= {WOFF_W{1'b0}};
         req_wdata_r <= {DATA_W{1'b0}};
         cnt_r       <= {WOFF_W{1'b0}};
         wb_data_r   <= {DATA_W{1'b0}};
         wb_hold_r   <= 1'b0;
         fill_word_r <= {DATA_W{1'b0}};
         replay_r    <= 1'b0;
      end else begin
         if (accept_s) begin
            req_write_r <= cpu_req_write;
            req_tag_r   <= get_tag(cpu_req_addr);
            req_idx_r   <= get_index(cpu_req_addr);
            req_woff_r  <= get_woff(cpu_req_addr);
            req_wdata_r <= cpu_req_wdata;
            replay_r    <= 1'b0;
         end else if (fill_s) begin
            replay_r    <= 1'b1;
         end
         if (cnt_clr_s) begin
            cnt_r <= {WOFF_W{1'b0}};
         end else if (cnt_inc_s) begin
            cnt_r <= cnt_r + {{(WOFF_W-1){1'b0}}, 1'b1};
         end
         // The array word is only valid in the first WB_WR cycle; keep it
         // for as long as memory stalls the write.
         if ((state_r == ST_WB_WR) && !wb_hold_r) begin
            wb_data_r <= arr_rdata;
         end
         wb_hold_r <= (state_r == ST_WB_WR) && !mem_ready;
         // The array port is busy writing the last refill word when the replay
         // address would have to be issued, so the requested word is captured
         // as it streams past and returned directly on the replay.
         if ((state_r == ST_RF_WAIT) && mem_rvalid && (cnt_r == req_woff_r)) begin
            fill_word_r <= mem_rdata;
         end
      end
   end

   // Next-state decode and all datapath/handshake outputs
   always_comb begin
      next_s         = state_r;
      accept_s       = 1'b0;
      cnt_clr_s      = 1'b0;
      cnt_inc_s      = 1'b0;
      fill_s         = 1'b0;
      set_dirty_s    = 1'b0;
      cpu_req_ready  = 1'b0;
      cpu_resp_valid = 1'b0;
      cpu_resp_rdata = {DATA_W{1'b0}};
      cpu_resp_hit   = 1'b0;
      arr_addr       = {(INDEX_W+WOFF_W){1'b0}};
      arr_we         = 1'b0;
      arr_wdata      = {DATA_W{1'b0}};
      mem_req_valid  = 1'b0;
      mem_req_write  = 1'b0;
      mem_addr       = {ADDR_W{1'b0}};
      mem_wdata      = {DATA_W{1'b0}};
      case (state_r)
         ST_IDLE: begin
            cpu_req_ready = 1'b1;
            if (cpu_req_valid) begin
               accept_s = 1'b1;
               arr_addr = {get_index(cpu_req_addr), get_woff(cpu_req_addr)};
               next_s   = ST_LOOKUP;
            end else begin
               next_s   = ST_IDLE;
            end
         end
         ST_LOOKUP: begin
            arr_addr = {req_idx_r, req_woff_r};
            if (hit_s) begin
               cpu_resp_valid = 1'b1;
               cpu_resp_hit   = !replay_r;
               next_s         = ST_IDLE;
               if (req_write_r) begin
                  arr_we      = 1'b1;
                  arr_wdata   = req_wdata_r;
                  set_dirty_s = 1'b1;
               end else begin
                  cpu_resp_rdata = replay_r ? fill_word_r : arr_rdata;
               end
            end else begin
               cnt_clr_s = 1'b1;
               next_s    = dirty_victim_s ? ST_WB_RD : ST_RF_REQ;
            end
         end
         ST_WB_RD: begin
            arr_addr = {req_idx_r, cnt_r};
            next_s   = ST_WB_WR;
         end
         ST_WB_WR: begin
            mem_req_valid = 1'b1;
            mem_req_write = 1'b1;
            mem_addr      = {victim_tag_s, req_idx_r, cnt_r, 2'b00};
            mem_wdata     = wb_hold_r ? wb_data_r : arr_rdata;
            if (mem_ready) begin
               if (cnt_r == CNT_LAST) begin
                  cnt_clr_s = 1'b1;
                  next_s    = ST_RF_REQ;
               end else begin
                  cnt_inc_s = 1'b1;
                  next_s    = ST_WB_RD;
               end
            end else begin
               next_s = ST_WB_WR;
            end
         end
         ST_RF_REQ: begin
            mem_req_valid = 1'b1;
            mem_addr      = {req_tag_r, req_idx_r, cnt_r, 2'b00};
            if (mem_ready) begin
               next_s = ST_RF_WAIT;
            end else begin
               next_s = ST_RF_REQ;
            end
         end
         ST_RF_WAIT: begin
            if (mem_rvalid) begin
               arr_we    = 1'b1;
               arr_addr  = {req_idx_r, cnt_r};
               arr_wdata = mem_rdata;
               if (cnt_r == CNT_LAST) begin
                  fill_s = 1'b1;
                  next_s = ST_LOOKUP;
               end else begin
                  cnt_inc_s = 1'b1;
                  next_s    = ST_RF_REQ;
               end
            end else begin
               next_s = ST_RF_WAIT;
            end
         end
         default: begin
            next_s = ST_IDLE;
         end
      endcase
   end

endmodule

// File: doc/dm_cache_fsm.md
Name: dm_cache_fsm

Overview:
- Sequencing controller for the direct-mapped cache: accepts one CPU request at a time and owns the tag, valid and dirty state.
- Performs hit/miss determination and drives the cache data array.
- Runs write-back and line-refill bursts to main memory over a valid/ready handshake.
- Sits between the CPU port and the cache data array / main memory models. It replaces the bare tag-compare flag with a complete miss-handling sequencer.

Parameters:
- ADDR_W, 32, byte address width
- TAG_W, 20, tag field width (address bits 31:12)
- INDEX_W, 8, line index width (address bits 11:4); 256 lines
- WOFF_W, 2, word-in-line offset width (address bits 3:2); 4 words per line
- DATA_W, 32, word width; address bits 1:0 are ignored

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req_valid  in  1  CPU request present
- cpu_req_write  in  1  1 = write, 0 = read
- cpu_req_addr  in  ADDR_W  request byte address
- cpu_req_wdata  in  DATA_W  write data
- cpu_req_ready  out  1  controller can accept a request
- cpu_resp_valid  out  1  one-cycle completion pulse
- cpu_resp_rdata  out  DATA_W  read data, valid with cpu_resp_valid
- cpu_resp_hit  out  1  request hit on its first lookup
- arr_addr  out  INDEX_W+WOFF_W  data array word address
- arr_we  out  1  data array write enable
- arr_wdata  out  DATA_W  data array write data
- arr_rdata  in  DATA_W  data array read data, 1-cycle read latency
- mem_req_valid  out  1  memory request
- mem_req_write  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  word-aligned memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ready  in  1  memory accepts request this cycle
- mem_rvalid  in  1  read data returned
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Interface: single clock clk; reset rst_n is asynchronous, active-low.
- Reset:
  - State goes to IDLE, burst counter to 0, all valid and dirty bits to 0.
  - All outputs are 0 except cpu_req_ready, which is 1.
  - Reset mid-burst abandons the operation; dirty data is lost by design.
  - Tag contents are don't-care after reset.
- States: IDLE, LOOKUP, WB_RD, WB_WR, RF_REQ, RF_WAIT.
- IDLE:
  - cpu_req_ready = 1.
  - On cpu_req_valid: latch write, addr and wdata; drive arr_addr = {index, woff} in the same cycle; go to LOOKUP.
- LOOKUP (hit = valid[idx] && tag[idx] == latched tag):
  - Read hit: cpu_resp_valid = 1 and cpu_resp_rdata = arr_rdata; go to IDLE.
  - Write hit: arr_we = 1 with latched wdata; dirty[idx] set; cpu_resp_valid = 1 and cpu_resp_rdata = 0; go to IDLE.
  - cpu_resp_hit = 1 only when the hit occurs on the first LOOKUP of the request.
  - Hit latency is 2 cycles from acceptance to response.
  - Miss with valid && dirty: cnt = 0, go to WB_RD. Any other miss: cnt = 0, go to RF_REQ.
- WB_RD: drive arr_addr = {idx, cnt}; go to WB_WR.
- WB_WR:
  - Register arr_rdata on entry; hold it on mem_wdata.
  - mem_req_valid = 1, mem_req_write = 1, mem_addr = {old tag, idx, cnt, 2'b00}.
  - On mem_ready: if cnt == 3, set cnt = 0 and go to RF_REQ; otherwise cnt++ and go to WB_RD.
- RF_REQ:
  - mem_req_valid = 1, mem_req_write = 0, mem_addr = {new tag, idx, cnt, 2'b00}.
  - On mem_ready go to RF_WAIT.
- RF_WAIT:
  - On mem_rvalid: arr_we = 1, arr_addr = {idx, cnt}, arr_wdata = mem_rdata.
  - If cnt == 3: tag[idx] = new tag, valid = 1, dirty = 0; go to LOOKUP, drive arr_addr for the requested word, and replay (the replay is a guaranteed hit).
  - Otherwise cnt++ and go to RF_REQ.
- Memory handshake rules:
  - mem_addr, mem_wdata and mem_req_write stay stable while mem_req_valid = 1 and mem_ready = 0.
  - At most one memory read is outstanding.
  - mem_rvalid is ignored outside RF_WAIT.
  - mem_ready and mem_rvalid asserted together in RF_REQ: only mem_ready is honoured.
- CPU handshake rules:
  - cpu_req_ready = 0 in every state except IDLE; requests offered while busy are not consumed.
  - A new request may be accepted in the cycle after cpu_resp_valid.
- Miss latency (zero-wait memory):
  - Clean miss: 4 × (request + data) + replay.
  - Dirty miss: adds 4 × (array read + write).
- cnt is WOFF_W bits and wraps only through the explicit cnt == 3 checks.

Decomposition:
- Shared package / include dm_cache_pkg:
  - TAG_W, INDEX_W, WOFF_W, DATA_W.
  - State encoding constants.
  - Field-extraction functions get_tag, get_index, get_woff.
- Sub-module dm_cache_tag_store:
  - tag/valid/dirty arrays with asynchronous-reset valid and dirty bits.
  - Combinational lookup producing hit, dirty_victim and victim_tag.
  - Write port for fill and set_dirty.

Test Plan:
- Cold read miss: read 0x12345104 after reset; memory returns 0xA0–0xA3 → exactly 4 mem reads at 0x12345100/104/108/10C, no mem writes; response rdata = 0xA1 with cpu_resp_hit = 0.
- Read hit: read 0x12345108 next → cpu_resp_valid 2 cycles after acceptance, rdata = 0xA2, cpu_resp_hit = 1, mem_req_valid stays 0.
- Dirty conflict: write 0xDEADBEEF to 0x1234510C (hit), then read 0xABCDE100 → 4 mem writes to 0x12345100–10C, the last carrying 0xDEADBEEF; then 4 reads from 0xABCDE100; response = first returned word.
- Backpressure: mem_ready held low 5 cycles in WB_WR and RF_REQ → state, mem_addr and mem_wdata held stable; burst completes correctly afterwards.
- Busy request: cpu_req_valid asserted with a second address during a refill → cpu_req_ready = 0; the request is serviced only after the first response.
- Reset mid-refill: drop rst_n after 2 of 4 refill words → outputs at reset values immediately; re-reading 0x12345104 misses again (cpu_resp_hit = 0).
